key_sw_conditioner: RTL and testbench

Front-end input stage for the DE10-Lite lab top level: it takes the raw, asynchronous, active-low KEY[1:0] pushbuttons and SW[9:0] slide switches and turns them into clean, synchronous signals. Outputs are debounced key levels, single-cycle press/release pulses, a synchronized switch bus, and a switch operand captured on KEY[0] press. The comparator/display logic of `top` consumes these outputs in place of raw KEY/SW, so mode changes fire exactly once per physical press.

---
 rtl/key_cond_pkg.sv | 19 +
 rtl/key_sw_conditioner_debounce_ch.sv | 123 ++++++++++++
 rtl/key_sw_conditioner.sv | 79 +++++++
 tb/tb_key_sw_conditioner.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and constants for the KEY/SW input conditioner.
//   db_state_e    : per-key debounce state
//   KEY_RELEASED  : raw level of an idle (released) pushbutton
//   NUM_KEYS/SW_W : pushbutton count and slide-switch bus width
package key_cond_pkg;

    localparam int unsigned NUM_KEYS = 2;
    localparam int unsigned SW_W     = 10;

    localparam logic KEY_RELEASED = 1'b1;

    typedef enum logic [1:0] {
        REL   = 2'd0,   // stable released
        CHK_P = 2'd1,   // press candidate, counting stable samples
        PRS   = 2'd2,   // stable pressed
        CHK_R = 2'd3    // release candidate, counting stable samples
    } db_state_e;

endpackage : key_cond_pkg

// File: rtl/key_sw_conditioner_debounce_ch.sv
// One pushbutton channel: synchronizer, debounce FSM with stable-sample
// counter, registered debounced level and one-cycle press/release pulses.
//   clk, rst      : clock, synchronous active-high reset
//   key_raw       : asynchronous active-low pushbutton
//   level         : debounced state, 1 = pressed
//   press_pulse   : one cycle on the debounced press edge
//   release_pulse : one cycle on the debounced release edge
module debounce_ch
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    // The candidate sample that entered the CHK state counts as the first
    // stable sample, so the counter only has to reach DEBOUNCE_CYCLES-1 and
    // always fits in CNT_W bits.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_c;
    logic                   level_q, press_q, release_q;

    // Synchronizer chain; idles at the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{KEY_RELEASED}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
        end
    end

    assign pressed = (sync_q[SYNC_STAGES-1] != KEY_RELEASED);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            REL: begin
                if (pressed) begin
                    state_d = CHK_P;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_P: begin
                if (!pressed) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRS: begin
                if (!pressed) begin
                    state_d = CHK_R;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_R: begin
                if (pressed) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_c = (state_q == PRS) || (state_q == CHK_R);

    // Registered level; pulses are its edges so they align with the level change.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_c;
            press_q   <= level_c & ~level_q;
            release_q <= ~level_c & level_q;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule : debounce_ch

// File: rtl/key_sw_conditioner.sv
// DE10-Lite input conditioner: debounced KEY levels and edge pulses,
// synchronized SW bus, and a SW operand captured on a KEY[0] press.
//   CLK, RST    : clock, synchronous active-high reset
//   KEY         : raw active-low pushbuttons (async)
//   SW          : raw slide switches (async)
//   KEY_LVL     : debounced key state, 1 = pressed
//   KEY_PRESS   : one-cycle debounced press pulses
//   KEY_RELEASE : one-cycle debounced release pulses
//   SW_SYNC     : synchronized (not debounced) switches
//   SW_CAP      : SW_SYNC captured on KEY[0] press, cleared on KEY[1] press
//   CAP_VALID   : SW_CAP holds a captured value
module key_sw_conditioner
    import key_cond_pkg::*;
#(
    parameter  int unsigned DEBOUNCE_CYCLES = 500000,
    parameter  int unsigned SYNC_STAGES     = 2,
    localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [SW_W-1:0]     SW,
    output logic [NUM_KEYS-1:0] KEY_LVL,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE,
    output logic [SW_W-1:0]     SW_SYNC,
    output logic [SW_W-1:0]     SW_CAP,
    output logic                CAP_VALID
);

    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_pipe_q;
    logic [SW_W-1:0]                  cap_q;
    logic                             cap_valid_q;

    // Independent debounce channel per pushbutton.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk           (CLK),
            .rst           (RST),
            .key_raw       (KEY[k]),
            .level         (KEY_LVL[k]),
            .press_pulse   (KEY_PRESS[k]),
            .release_pulse (KEY_RELEASE[k])
        );
    end

    // Switch synchronizer; last stage is the output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_pipe_q <= '0;
        end else begin
            sw_pipe_q <= {sw_pipe_q[SYNC_STAGES-2:0], SW};
        end
    end

    assign SW_SYNC = sw_pipe_q[SYNC_STAGES-1];

    // Operand capture; a KEY[1] clear takes priority over a KEY[0] capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
        end else if (KEY_PRESS[1]) begin
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
        end else if (KEY_PRESS[0]) begin
            cap_q       <= SW_SYNC;
            cap_valid_q <= 1'b1;
        end
    end

    assign SW_CAP    = cap_q;
    assign CAP_VALID = cap_valid_q;

endmodule : key_sw_conditioner

// File: tb/tb_key_sw_conditioner.sv
// Directed bench for key_sw_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2
// (key latency 7 cycles, switch latency 2 cycles).
module tb_key_sw_conditioner;

    localparam int LAT = 7;

    logic       CLK;
    logic       RST;
    logic [1:0] KEY;
    logic [9:0] SW;
    logic [1:0] KEY_LVL;
    logic [1:0] KEY_PRESS;
    logic [1:0] KEY_RELEASE;
    logic [9:0] SW_SYNC;
    logic [9:0] SW_CAP;
    logic       CAP_VALID;

    int checks = 0;
    int errors = 0;

    key_sw_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .KEY         (KEY),
        .SW          (SW),
        .KEY_LVL     (KEY_LVL),
        .KEY_PRESS   (KEY_PRESS),
        .KEY_RELEASE (KEY_RELEASE),
        .SW_SYNC     (SW_SYNC),
        .SW_CAP      (SW_CAP),
        .CAP_VALID   (CAP_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // After a raw edge on the keys in mask, follow 9 cycles: the level flips
    // and a single pulse fires exactly LAT cycles after the edge.
    task automatic watch(input string tag, input logic [1:0] mask, input bit is_press,
                         input logic [1:0] lvl_before);
        logic [1:0] lvl_after;
        lvl_after = is_press ? (lvl_before | mask) : (lvl_before & ~mask);
        for (int c = 1; c <= LAT + 2; c++) begin
            step(1);
            check({tag, "_lvl"}, 32'(KEY_LVL), 32'((c >= LAT) ? lvl_after : lvl_before));
            check({tag, "_press"}, 32'(KEY_PRESS), 32'((c == LAT && is_press) ? mask : 2'b00));
            check({tag, "_release"}, 32'(KEY_RELEASE), 32'((c == LAT && !is_press) ? mask : 2'b00));
        end
    endtask

    initial begin
        RST = 1'b1;
        KEY = 2'b11;
        SW  = 10'h155;

        // Reset: everything zero while RST is held.
        step(2);
        check("rst_lvl", 32'(KEY_LVL), 32'h0);
        check("rst_press", 32'(KEY_PRESS), 32'h0);
        check("rst_release", 32'(KEY_RELEASE), 32'h0);
        check("rst_sw_sync", 32'(SW_SYNC), 32'h0);
        check("rst_sw_cap", 32'(SW_CAP), 32'h0);
        check("rst_cap_valid", 32'(CAP_VALID), 32'h0);

        // SW_SYNC follows SW two cycles after reset release.
        RST = 1'b0;
        step(1);
        check("sw_sync_1", 32'(SW_SYNC), 32'h0);
        step(1);
        check("sw_sync_2", 32'(SW_SYNC), 32'h155);

        // Clean press/release on KEY[0]; the press captures SW_SYNC.
        KEY[0] = 1'b0;
        watch("clean_press", 2'b01, 1'b1, 2'b00);
        check("clean_cap", 32'(SW_CAP), 32'h155);
        check("clean_cap_valid", 32'(CAP_VALID), 32'h1);
        KEY[0] = 1'b1;
        watch("clean_release", 2'b01, 1'b0, 2'b01);

        // Bounce on KEY[1]: 2-cycle toggles never qualify.
        for (int p = 0; p < 4; p++) begin
            KEY[1] = p[0];
            for (int c = 0; c < 2; c++) begin
                step(1);
                check("bounce_press", 32'(KEY_PRESS), 32'h0);
                check("bounce_lvl", 32'(KEY_LVL), 32'h0);
            end
        end
        KEY[1] = 1'b0;
        watch("bounce_settle", 2'b10, 1'b1, 2'b00);
        check("clear_cap", 32'(SW_CAP), 32'h0);
        check("clear_cap_valid", 32'(CAP_VALID), 32'h0);
        KEY[1] = 1'b1;
        watch("k1_release", 2'b10, 1'b0, 2'b10);

        // Capture, then overwrite with a second press.
        SW     = 10'b01_0101_0001;
        KEY[0] = 1'b0;
        watch("cap1_press", 2'b01, 1'b1, 2'b00);
        check("cap1", 32'(SW_CAP), 32'h151);
        check("cap1_valid", 32'(CAP_VALID), 32'h1);
        KEY[0] = 1'b1;
        watch("cap1_release", 2'b01, 1'b0, 2'b01);
        SW     = 10'h00C;
        KEY[0] = 1'b0;
        watch("cap2_press", 2'b01, 1'b1, 2'b00);
        check("cap2", 32'(SW_CAP), 32'h00C);
        check("cap2_valid", 32'(CAP_VALID), 32'h1);
        KEY[0] = 1'b1;
        watch("cap2_release", 2'b01, 1'b0, 2'b01);

        // Simultaneous press: both pulse together and the clear wins.
        KEY = 2'b00;
        watch("both_press", 2'b11, 1'b1, 2'b00);
        check("both_cap", 32'(SW_CAP), 32'h0);
        check("both_cap_valid", 32'(CAP_VALID), 32'h0);
        KEY = 2'b11;
        watch("both_release", 2'b11, 1'b0, 2'b11);

        // Reset two cycles into CHK_P with KEY[0] held: pending press discarded.
        KEY[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(1);
            check("pre_rst_lvl", 32'(KEY_LVL), 32'h0);
        end
        RST = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step(1);
            check("mid_rst_press", 32'(KEY_PRESS), 32'h0);
            check("mid_rst_lvl", 32'(KEY_LVL), 32'h0);
            check("mid_rst_sw_sync", 32'(SW_SYNC), 32'h0);
        end
        RST = 1'b0;
        watch("post_rst_press", 2'b01, 1'b1, 2'b00);
        check("post_rst_cap", 32'(SW_CAP), 32'h00C);
        check("post_rst_cap_valid", 32'(CAP_VALID), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_key_sw_conditioner
